// File: rtl/test_monitor_pkg.sv
// Shared definitions for the test monitor: verdict encoding and default
// constants, also used by the core-level bench.
package test_monitor_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_PASS    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_HANG    = 3'd4
    } status_e;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR    = 32'h0000_1000;
    localparam logic [31:0] DEFAULT_TIMEOUT_CYCLES = 32'd100000;
    localparam logic [7:0]  DEFAULT_HANG_LIMIT     = 8'd16;

    function automatic logic is_terminal(input status_e s);
        return s != ST_RUN;
    endfunction

endpackage

// File: rtl/test_monitor_sat_counter.sv
// Width-parameterised up-counter with enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/test_monitor.sv
// Watches a core's retire stream and data stores, and latches a sticky
// verdict (PASS/FAIL/TIMEOUT/HANG) plus cycle and retire statistics.
module test_monitor
    import test_monitor_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = DEFAULT_TOHOST_ADDR,
    parameter logic [31:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [7:0]  HANG_LIMIT     = DEFAULT_HANG_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        retire,
    input  logic [31:0] pc,
    input  logic        d_w_enable,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_data,
    output logic [2:0]  status,
    output logic        done,
    output logic [30:0] fail_id,
    output logic [31:0] cycle_count,
    output logic [31:0] retire_count
);

    status_e     status_q, status_d;
    logic        done_q, done_d;
    logic [30:0] fail_id_q, fail_id_d;
    logic [31:0] last_pc_q, last_pc_d;
    logic        last_pc_valid_q, last_pc_valid_d;
    logic [7:0]  same_cnt_q, same_cnt_d;

    logic running;
    logic tohost_hit;
    logic end_store;
    logic hang_event;
    logic timeout_event;

    assign running    = !is_terminal(status_q);
    assign tohost_hit = running && d_w_enable && (d_addr == TOHOST_ADDR);
    // Even tohost values are syscall-style requests and never end the test.
    assign end_store  = tohost_hit && d_data[0];

    assign timeout_event = running &&
        (({1'b0, cycle_count} + 33'd1) == {1'b0, TIMEOUT_CYCLES});

    // The first retire after reset only seeds the last-PC register.
    always_comb begin
        last_pc_d       = last_pc_q;
        last_pc_valid_d = last_pc_valid_q;
        same_cnt_d      = same_cnt_q;
        hang_event      = 1'b0;
        if (running && retire) begin
            if (last_pc_valid_q && (pc == last_pc_q)) begin
                if (same_cnt_q != 8'hFF) begin
                    same_cnt_d = same_cnt_q + 8'd1;
                end
                hang_event = (same_cnt_d == HANG_LIMIT);
            end else begin
                same_cnt_d      = 8'd0;
                last_pc_d       = pc;
                last_pc_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        status_d  = status_q;
        fail_id_d = fail_id_q;
        if (running) begin
            if (end_store) begin
                if (d_data == 32'h1) begin
                    status_d = ST_PASS;
                end else begin
                    status_d  = ST_FAIL;
                    fail_id_d = d_data[31:1];
                end
            end else if (hang_event) begin
                status_d = ST_HANG;
            end else if (timeout_event) begin
                status_d = ST_TIMEOUT;
            end
        end
        done_d = is_terminal(status_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q        <= ST_RUN;
            done_q          <= 1'b0;
            fail_id_q       <= '0;
            last_pc_q       <= '0;
            last_pc_valid_q <= 1'b0;
            same_cnt_q      <= '0;
        end else begin
            status_q        <= status_d;
            done_q          <= done_d;
            fail_id_q       <= fail_id_d;
            last_pc_q       <= last_pc_d;
            last_pc_valid_q <= last_pc_valid_d;
            same_cnt_q      <= same_cnt_d;
        end
    end

    // Counters advance on the terminating edge too, then freeze.
    sat_counter #(.WIDTH(32)) u_cycle_counter (
        .clk   (clk),
        .reset (reset),
        .en    (running),
        .count (cycle_count)
    );

    sat_counter #(.WIDTH(32)) u_retire_counter (
        .clk   (clk),
        .reset (reset),
        .en    (running && retire),
        .count (retire_count)
    );

    assign status  = status_q;
    assign done    = done_q;
    assign fail_id = fail_id_q;

endmodule

// File: tb/tb_test_monitor.sv
// Self-checking bench for test_monitor: directed phases with randomized
// filler traffic, checked against a queue-based verdict model.
module tb_test_monitor;

    localparam logic [31:0] TOHOST  = 32'h0000_1000;
    localparam longint      TIMEOUT = 100000;
    localparam int          HLIMIT  = 16;
    localparam logic [31:0] HANG_PC = 32'h8000_0040;

    localparam int S_RUN = 0, S_PASS = 1, S_FAIL = 2, S_TIMEOUT = 3, S_HANG = 4;

    logic        clk;
    logic        reset;
    logic        retire;
    logic [31:0] pc;
    logic        d_w_enable;
    logic [31:0] d_addr;
    logic [31:0] d_data;

    logic [2:0]  status,       to_status;
    logic        done,         to_done;
    logic [30:0] fail_id,      to_fail_id;
    logic [31:0] cycle_count,  to_cycle_count;
    logic [31:0] retire_count, to_retire_count;

    int total = 0;
    int bad   = 0;

    int            m_status;
    logic [30:0]   m_fail_id;
    longint        m_cycles;
    longint        m_retires;
    logic [31:0]   hist[$];

    test_monitor dut (
        .clk          (clk),
        .reset        (reset),
        .retire       (retire),
        .pc           (pc),
        .d_w_enable   (d_w_enable),
        .d_addr       (d_addr),
        .d_data       (d_data),
        .status       (status),
        .done         (done),
        .fail_id      (fail_id),
        .cycle_count  (cycle_count),
        .retire_count (retire_count)
    );

    test_monitor #(.TIMEOUT_CYCLES(32'd50)) dut_to (
        .clk          (clk),
        .reset        (reset),
        .retire       (retire),
        .pc           (pc),
        .d_w_enable   (d_w_enable),
        .d_addr       (d_addr),
        .d_data       (d_data),
        .status       (to_status),
        .done         (to_done),
        .fail_id      (to_fail_id),
        .cycle_count  (to_cycle_count),
        .retire_count (to_retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        m_status  = S_RUN;
        m_fail_id = '0;
        m_cycles  = 0;
        m_retires = 0;
        hist.delete();
    endtask

    // A hang is a trailing run of HLIMIT+1 identical retired PCs.
    task automatic modelEdge(input logic r, input logic [31:0] p, input logic we,
                             input logic [31:0] a, input logic [31:0] d);
        int  run;
        bit  hang;
        bit  tmo;
        if (m_status != S_RUN) return;
        hang = 0;
        if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
        tmo = (m_cycles == TIMEOUT);
        if (r) begin
            if (m_retires < 64'hFFFF_FFFF) m_retires++;
            hist.push_back(p);
            run = 0;
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] != p) break;
                run++;
            end
            hang = (run == HLIMIT + 1);
            if (hist.size() > 40) void'(hist.pop_front());
        end
        if (we && a == TOHOST && d[0]) begin
            if (d == 32'h1) m_status = S_PASS;
            else begin
                m_status  = S_FAIL;
                m_fail_id = d >> 1;
            end
        end else if (hang) m_status = S_HANG;
        else if (tmo) m_status = S_TIMEOUT;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".status"},  {29'd0, status}, 32'(m_status));
        checkValue({tag, ".done"},    {31'd0, done},   {31'd0, m_status != S_RUN});
        checkValue({tag, ".fail_id"}, {1'b0, fail_id}, {1'b0, m_fail_id});
        checkValue({tag, ".cycles"},  cycle_count,     32'(m_cycles));
        checkValue({tag, ".retires"}, retire_count,    32'(m_retires));
    endtask

    // Drives one cycle of inputs, lets the edge happen, then advances the model.
    task automatic applyStimulus(input logic r, input logic [31:0] p, input logic we,
                                 input logic [31:0] a, input logic [31:0] d);
        retire     = r;
        pc         = p;
        d_w_enable = we;
        d_addr     = a;
        d_data     = d;
        @(posedge clk);
        if (!reset) modelEdge(r, p, we, a, d);
        #1;
    endtask

    function automatic logic [31:0] otherAddr();
        return TOHOST + 32'(4 * $urandom_range(1, 1000));
    endfunction

    task automatic randomStep(input string tag);
        applyStimulus(1'($urandom), $urandom, 1'($urandom), otherAddr(), $urandom);
        checkOutput(tag);
    endtask

    task automatic applyReset(input string tag);
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput({tag, ".inreset"});
        applyStimulus(1'b1, $urandom, 1'b1, TOHOST, 32'h1);
        applyStimulus(1'b1, $urandom, 1'b1, TOHOST, 32'h7);
        reset = 1'b0;
        checkOutput({tag, ".released"});
    endtask

    initial begin
        int to_ret;
        reset      = 1'b1;
        retire     = 1'b0;
        pc         = '0;
        d_w_enable = 1'b0;
        d_addr     = '0;
        d_data     = '0;
        modelReset();
        #2;
        checkOutput("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Pass after exactly 20 retires, then verdict is sticky.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, $urandom, 1'($urandom), otherAddr(), $urandom);
            checkOutput("pass_pre");
        end
        applyStimulus(1'b0, $urandom, 1'b1, TOHOST, 32'h1);
        checkOutput("pass_hit");
        checkValue("pass_status_const", {29'd0, status}, 32'(S_PASS));
        checkValue("pass_retires_const", retire_count, 32'd20);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, $urandom, 1'b1, TOHOST, 32'h7);
            checkOutput("pass_sticky");
        end

        // Fail with id 3, later pass store is ignored.
        applyReset("rst_fail");
        for (int i = 0; i < 5; i++) randomStep("fail_pre");
        applyStimulus(1'b1, $urandom, 1'b1, TOHOST, 32'h7);
        checkOutput("fail_hit");
        checkValue("fail_id_const", {1'b0, fail_id}, 32'd3);
        applyStimulus(1'b0, $urandom, 1'b1, TOHOST, 32'h1);
        checkOutput("fail_sticky");
        checkValue("fail_status_const", {29'd0, status}, 32'(S_FAIL));

        // Syscall-style and off-address stores leave the run alone.
        applyReset("rst_ignore");
        applyStimulus(1'b1, $urandom, 1'b1, TOHOST, 32'h6);
        checkOutput("ignore_even");
        applyStimulus(1'b1, $urandom, 1'b1, TOHOST + 32'd4, 32'h1);
        checkOutput("ignore_addr");
        checkValue("ignore_status_const", {29'd0, status}, 32'(S_RUN));
        checkValue("ignore_cycles_const", cycle_count, 32'd2);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'($urandom), $urandom, 1'b1, TOHOST, {$urandom_range(0, 1000), 1'b0});
            checkOutput("ignore_rand");
        end

        // Async reset between edges clears everything at once.
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("async_reset");
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) randomStep("after_async");
        checkValue("after_async_cycles_const", cycle_count, 32'd6);

        // Hang on the 17th same-PC retire.
        applyReset("rst_hang");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, HANG_PC, 1'b0, otherAddr(), $urandom);
            checkOutput("hang_seq");
        end
        checkValue("hang_status_const", {29'd0, status}, 32'(S_HANG));
        applyStimulus(1'b1, HANG_PC, 1'b1, TOHOST, 32'h1);
        checkOutput("hang_sticky");

        // Tohost store on the hanging edge wins.
        applyReset("rst_prio");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, HANG_PC, 1'b0, otherAddr(), $urandom);
            checkOutput("prio_seq");
        end
        applyStimulus(1'b1, HANG_PC, 1'b1, TOHOST, 32'h1);
        checkOutput("prio_hit");
        checkValue("prio_status_const", {29'd0, status}, 32'(S_PASS));

        // Random mix of two PCs with gaps exercises run breaks.
        applyReset("rst_mix");
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 11) == 0) ? HANG_PC + 32'd4 : HANG_PC,
                          1'($urandom), otherAddr(), $urandom);
            checkOutput("mix");
        end

        // Timeout instance: verdict after the 50th edge, counters frozen after.
        applyReset("rst_timeout");
        to_ret = 0;
        for (int e = 1; e <= 60; e++) begin
            retire = 1'($urandom);
            applyStimulus(retire, $urandom, 1'($urandom), otherAddr(), $urandom);
            if (e <= 50 && retire) to_ret++;
            checkOutput("to_main");
            checkValue($sformatf("to_status_e%0d", e), {29'd0, to_status},
                       (e >= 50) ? 32'(S_TIMEOUT) : 32'(S_RUN));
            checkValue($sformatf("to_done_e%0d", e), {31'd0, to_done}, {31'd0, e >= 50});
            checkValue($sformatf("to_cycles_e%0d", e), to_cycle_count,
                       (e >= 50) ? 32'd50 : 32'(e));
            checkValue($sformatf("to_retires_e%0d", e), to_retire_count, 32'(to_ret));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
